// File: rtl/mdu_pkg.sv
// Shared op encodings, FSM state type and op-class helpers for the iterative MDU.
// MDU_MADD_EN enables the multiply-accumulate op codes in the class decode.
package mdu_pkg;

    localparam int unsigned MDU_OP_W = 4;

    localparam logic [MDU_OP_W-1:0] MDU_NONE  = 4'h0;
    localparam logic [MDU_OP_W-1:0] MDU_MULT  = 4'h1;
    localparam logic [MDU_OP_W-1:0] MDU_MULTU = 4'h2;
    localparam logic [MDU_OP_W-1:0] MDU_DIV   = 4'h3;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 4'h4;
    localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 4'h5;
    localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 4'h6;
    localparam logic [MDU_OP_W-1:0] MDU_MADD  = 4'h7;
    localparam logic [MDU_OP_W-1:0] MDU_MADDU = 4'h8;
    localparam logic [MDU_OP_W-1:0] MDU_MSUB  = 4'h9;
    localparam logic [MDU_OP_W-1:0] MDU_MSUBU = 4'hA;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    // Ops that use the multiplier and MUL_CYCLES latency
    function automatic logic is_mul_class(input logic [MDU_OP_W-1:0] op);
        logic r;
        r = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_MADD_EN
        r = r || (op == MDU_MADD) || (op == MDU_MADDU) ||
                 (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
        return r;
    endfunction

    function automatic logic is_div_class(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Combinational signed/unsigned divider: quotient truncates toward zero,
// remainder follows the dividend's sign; divide-by-zero is flagged.
module mdu_div_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] b_safe;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;

    // Magnitude divide; the most-negative / -1 case wraps back to itself
    always_comb begin
        a_neg       = is_signed & dividend[WIDTH-1];
        b_neg       = is_signed & divisor[WIDTH-1];
        a_mag       = a_neg ? (~dividend + WIDTH'(1)) : dividend;
        b_mag       = b_neg ? (~divisor + WIDTH'(1)) : divisor;
        div_by_zero = (divisor == '0);
        b_safe      = div_by_zero ? WIDTH'(1) : b_mag;
        q_mag       = a_mag / b_safe;
        r_mag       = a_mag % b_safe;
        quotient    = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
        remainder   = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;
    end

endmodule

// File: rtl/mdu_iter.sv
// Multiply/divide unit with HI/LO, fixed-latency busy emulation and flush.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    src_a,
    input  logic [WIDTH-1:0]    src_b,
    input  logic                flush,
    output logic                busy,
    output logic [WIDTH-1:0]    hi,
    output logic [WIDTH-1:0]    lo
);

    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int unsigned PROD_W     = 2 * WIDTH;

    mdu_state_e          state_q;
    mdu_state_e          state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [MDU_OP_W-1:0] op_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [WIDTH-1:0]    hi_d;
    logic [WIDTH-1:0]    lo_d;
    logic                busy_d;
    logic                capture;

    logic                mul_signed;
    logic [PROD_W-1:0]   a_ext;
    logic [PROD_W-1:0]   b_ext;
    logic [PROD_W-1:0]   product;
    logic [PROD_W-1:0]   mul_result;
    logic [WIDTH-1:0]    quotient;
    logic [WIDTH-1:0]    remainder;
    logic                div_by_zero;

    // Low 2*WIDTH bits of the extended product give the signed or unsigned result
    always_comb begin
        mul_signed = (op_q == MDU_MULT) || (op_q == MDU_MADD) || (op_q == MDU_MSUB);
        a_ext      = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext      = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        product    = a_ext * b_ext;
        mul_result = product;
`ifdef MDU_MADD_EN
        // Accumulator base is HI/LO as they stand at the completion edge
        if ((op_q == MDU_MADD) || (op_q == MDU_MADDU)) begin
            mul_result = {hi, lo} + product;
        end else if ((op_q == MDU_MSUB) || (op_q == MDU_MSUBU)) begin
            mul_result = {hi, lo} - product;
        end
`endif
    end

    mdu_div_core #(
        .WIDTH (WIDTH)
    ) u_div_core (
        .is_signed   (op_q == MDU_DIV),
        .dividend    (a_q),
        .divisor     (b_q),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Next-state, counter and HI/LO update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi;
        lo_d    = lo;
        capture = 1'b0;

        case (state_q)
            MDU_IDLE: begin
                if (start && !flush) begin
                    if (is_mul_class(op)) begin
                        state_d = MDU_BUSY;
                        cnt_d   = CNT_W'(MUL_CYCLES);
                        capture = 1'b1;
                    end else if (is_div_class(op)) begin
                        state_d = MDU_BUSY;
                        cnt_d   = CNT_W'(DIV_CYCLES);
                        capture = 1'b1;
                    end else if (op == MDU_MTHI) begin
                        hi_d = src_a;
                    end else if (op == MDU_MTLO) begin
                        lo_d = src_a;
                    end
                end
            end
            MDU_BUSY: begin
                if (flush) begin
                    state_d = MDU_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = MDU_IDLE;
                    cnt_d   = '0;
                    if (is_div_class(op_q)) begin
                        if (!div_by_zero) begin
                            lo_d = quotient;
                            hi_d = remainder;
                        end
                    end else begin
                        {hi_d, lo_d} = mul_result;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase

        busy_d = (state_d == MDU_BUSY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            busy    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            op_q    <= MDU_NONE;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
            hi      <= hi_d;
            lo      <= lo_d;
            if (capture) begin
                op_q <= op;
                a_q  <= src_a;
                b_q  <= src_b;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10),
// against an arithmetic reference model of HI/LO and latency.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    mdu_iter #(
        .WIDTH      (32),
        .MUL_CYCLES (5),
        .DIV_CYCLES (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: architectural effect of one accepted op on HI/LO, plus its busy length
    task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        longint      p;
        int          sa;
        int          sb;
        logic [63:0] acc;
        lat = 0;
        sa  = a;
        sb  = b;
        acc = {m_hi, m_lo};
        case (o)
            4'h1: begin p = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = p; lat = 5; end
            4'h2: begin p = longint'({32'h0, a}) * longint'({32'h0, b}); {m_hi, m_lo} = p; lat = 5; end
            4'h3: begin
                lat = 10;
                if (b != 0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        m_lo = a;
                        m_hi = 0;
                    end else begin
                        m_lo = sa / sb;
                        m_hi = sa % sb;
                    end
                end
            end
            4'h4: begin
                lat = 10;
                if (b != 0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            4'h5: m_hi = a;
            4'h6: m_lo = a;
`ifdef MDU_MADD_EN
            4'h7: begin p = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = acc + p; lat = 5; end
            4'h8: begin p = longint'({32'h0, a}) * longint'({32'h0, b}); {m_hi, m_lo} = acc + p; lat = 5; end
            4'h9: begin p = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = acc - p; lat = 5; end
            4'hA: begin p = longint'({32'h0, a}) * longint'({32'h0, b}); {m_hi, m_lo} = acc - p; lat = 5; end
`endif
            default: ;
        endcase
    endtask

    // Issue one op, scramble operands while busy, then check latency and HI/LO
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        int lat;
        int n;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        model(o, a, b, lat);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            src_a = $urandom;
            src_b = $urandom;
            @(posedge clk); #1;
        end
        check({tag, " lat"}, 64'(n), 64'(lat));
        check({tag, " hi"}, 64'(hi), 64'(m_hi));
        check({tag, " lo"}, 64'(lo), 64'(m_lo));
    endtask

    initial begin
        int lat;
        int n;
        int r;
        logic [3:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 4'h0; src_a = '0; src_b = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'(0));
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        run_op("mult", 4'h1, 32'hFFFF_FFFE, 32'd3);
        check("mult hi const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        check("mult lo const", 64'(lo), 64'h0000_0000_FFFF_FFFA);
        run_op("multu", 4'h2, 32'hFFFF_FFFE, 32'd3);
        check("multu hi const", 64'(hi), 64'h2);
        run_op("div", 4'h3, 32'hFFFF_FFF9, 32'd2);
        check("div lo const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        check("div hi const", 64'(hi), 64'h0000_0000_FFFF_FFFF);

        run_op("mthi", 4'h5, 32'h11, 32'h0);
        run_op("mtlo", 4'h6, 32'h22, 32'h0);
        run_op("divu0", 4'h4, 32'd7, 32'd0);
        check("divu0 hi const", 64'(hi), 64'h11);
        check("divu0 lo const", 64'(lo), 64'h22);

        run_op("divovf", 4'h3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("divovf lo const", 64'(lo), 64'h8000_0000);
        check("divovf hi const", 64'(hi), 64'h0);

        // Flush on the third busy cycle kills the multiply
        run_op("mthi2", 4'h5, 32'hAAAA, 32'h0);
        run_op("mtlo2", 4'h6, 32'hBBBB, 32'h0);
        @(negedge clk);
        start = 1'b1; op = 4'h1; src_a = 32'd6; src_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        check("flush busy1", 64'(busy), 64'(1));
        repeat (2) @(posedge clk);
        #1;
        check("flush busy3", 64'(busy), 64'(1));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush busy off", 64'(busy), 64'(0));
        repeat (8) @(posedge clk);
        #1;
        check("flush hi kept", 64'(hi), 64'(m_hi));
        check("flush lo kept", 64'(lo), 64'(m_lo));

        // start together with flush issues nothing
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 4'h6; src_a = 32'h55;
        @(posedge clk); #1;
        op = 4'h3; src_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("sf lo kept", 64'(lo), 64'(m_lo));
        check("sf busy", 64'(busy), 64'(0));

        // start held through a multiply is ignored until the first idle cycle
        @(negedge clk);
        start = 1'b1; op = 4'h1; src_a = 32'd3; src_b = 32'd4;
        @(posedge clk); #1;
        model(4'h1, 32'd3, 32'd4, lat);
        op = 4'h4; src_a = 32'd9; src_b = 32'd2;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        check("b2b mult lat", 64'(n), 64'(lat));
        check("b2b mult lo", 64'(lo), 64'(m_lo));
        @(posedge clk); #1;
        start = 1'b0;
        model(4'h4, 32'd9, 32'd2, lat);
        check("b2b divu issued", 64'(busy), 64'(1));
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        check("b2b divu lat", 64'(n), 64'(lat));
        check("b2b divu lo", 64'(lo), 64'd4);
        check("b2b divu hi", 64'(hi), 64'd1);

        // Multiply-accumulate codes (disabled build treats them as NONE)
        run_op("madd mthi", 4'h5, 32'h0, 32'h0);
        run_op("madd mtlo", 4'h6, 32'hFFFF_FFFF, 32'h0);
        run_op("maddu", 4'h8, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        check("maddu hi const", 64'(hi), 64'h1);
        check("maddu lo const", 64'(lo), 64'h0);
`else
        check("maddu hi const", 64'(hi), 64'h0);
        check("maddu lo const", 64'(lo), 64'hFFFF_FFFF);
`endif

        // Randomised ops including invalid codes and divide corner operands
        for (int i = 0; i < 24; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            r  = $urandom_range(0, 7);
            if (r == 0) rb = 32'h0;
            else if (r == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (r == 2) rb = 32'($urandom_range(1, 9));
            run_op("rand", ro, ra, rb);
        end

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; op = 4'h3; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("async busy", 64'(busy), 64'(0));
        check("async hi", 64'(hi), 64'(0));
        check("async lo", 64'(lo), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
